line_steer_pwm: RTL and testbench
=================================

Name: line_steer_pwm

Overview:
- Downstream consumer of the line-follow display stage, in the 50 MHz domain.
- Takes the per-frame signed centroid error and detected flag and runs a PD steering law.
- Converts the result into differential left/right motor duty and generates two PWM outputs.
- Lost-line supervision holds the last steer for a bounded number of frames, then stops the motors.

Parameters:
- PWM_BITS, 10, duty/counter width; PWM period = 2^PWM_BITS ticks
- PRESCALE, 49, clk cycles per PWM tick minus 1 (50 MHz -> ~977 Hz PWM)
- KP, 3, proportional multiplier (unsigned integer)
- KD, 2, derivative multiplier (unsigned integer)
- GAIN_SHIFT, 2, arithmetic right shift applied to P+D sum
- BASE_DUTY, 512, nominal duty of both motors
- STEER_MAX, 400, symmetric saturation limit of steer
- LOST_FRAMES, 15, consecutive undetected frames before STOP
- SLEW_STEP, 32, max per-frame steer change (optional feature only)

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  motor enable; 0 forces IDLE
- err_valid  in  1  one-cycle strobe per frame, already synchronised to clk
- error  in  16  signed centroid error; positive = line right of centre
- detected  in  1  line found this frame; sampled with err_valid
- pwm_left  out  1  left motor PWM
- pwm_right  out  1  right motor PWM
- duty_left  out  PWM_BITS  duty currently applied to pwm_left
- duty_right  out  PWM_BITS  duty currently applied to pwm_right
- steer  out  16  signed saturated steer of the last processed frame
- state  out  2  0=IDLE 1=TRACK 2=HOLD 3=STOP
- lost  out  1  high in HOLD or STOP

Behaviour:
Reset:
- Asynchronous, active-high.
- All outputs 0; state IDLE.
- e_prev, lost_cnt, prescaler and PWM counter are 0.
- Pending duties are 0.

FSM (evaluated on err_valid; enable=0 has priority in every state):
- Any state, enable=0: -> IDLE; pending duties 0; lost_cnt 0.
- IDLE, err_valid & detected: -> TRACK; D term forced 0.
- TRACK, err_valid & detected: stay; compute PD.
- TRACK, err_valid & !detected: -> HOLD; lost_cnt=1; steer and duties unchanged.
- HOLD, err_valid & detected: -> TRACK; D term forced 0; lost_cnt 0.
- HOLD, err_valid & !detected: lost_cnt+1; when it reaches LOST_FRAMES -> STOP.
- HOLD, LOST_FRAMES=1: the first miss goes straight from TRACK to STOP.
- STOP: pending duties 0; err_valid & detected -> TRACK with D forced 0.

Arithmetic (signed, 32-bit internal):
- p = error*KP; d = (error - e_prev)*KD.
- s = (p+d) >>> GAIN_SHIFT (arithmetic shift, floor toward minus infinity).
- steer = clamp(s, -STEER_MAX, +STEER_MAX).
- left = clamp(BASE_DUTY + steer, 0, 2^PWM_BITS-1); right = clamp(BASE_DUTY - steer, 0, 2^PWM_BITS-1).
- e_prev updates only on detected frames.

Pipeline:
- err_valid at cycle N: stage 1 (products) at N+1.
- Stage 2 (sum, shift, saturate, duty) at N+2.
- steer, state and pending duties are visible at N+2.
- Fully pipelined: back-to-back strobes are each processed in order.

PWM:
- Prescaler counts 0..PRESCALE; the PWM counter advances once per wrap.
- Pending duties are copied to duty_left/right only when the PWM counter wraps to 0, so there is never a glitched period.
- pwm_x = (cnt < duty_x): duty 0 gives constant low; max duty gives high for 2^PWM_BITS-1 of 2^PWM_BITS ticks.
- Effect of reset mid-period: outputs go low immediately.

Optional Feature:
- Macro: STEER_SLEW_EN.
- Defined: after saturation, steer is limited to prev_steer ± SLEW_STEP per processed frame.
  - prev_steer resets to 0 on IDLE and STOP entry.
  - Adds no pipeline cycles.
- Undefined: steer changes immediately; SLEW_STEP is unused.

Decomposition:
- Shared package line_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_TRACK, ST_HOLD, ST_STOP;
  - the default PWM_BITS;
  - a signed saturate function.
- One sub-module, pwm_gen: prescaler, counter, period-boundary duty latch, compare.
  - It is instantiated once with two duty channels.
- FSM and PD datapath stay in the top body.

Test Plan:
1. Reset, enable=1, err=+40 detected -> at N+2: state=TRACK, steer=30, pending left=542, right=482. duty outputs change only at the next PWM wrap.
2. Then err=+80 detected -> steer=(240+80)>>>2=80, left=592, right=432. Then err=-40 from IDLE (after enable toggle) -> steer=-30, left=482, right=542.
3. Saturation: err=+1000 detected from IDLE -> steer=400, left=912, right=112. Then err=+2000 -> left=912 (steer still 400).
4. Lost line: after TRACK, 14 undetected strobes -> HOLD, duties unchanged, lost=1. 15th -> STOP, duties 0 at next wrap. Detected strobe -> TRACK with D=0.
5. enable dropped in the same cycle as err_valid -> IDLE wins, duties 0. Assert reset mid-PWM-period -> pwm_left/right low immediately, state=0.
6. STEER_SLEW_EN defined, err=+1000 from IDLE -> steer 32, 64, 96 on successive frames until 400.

Source files
------------

// File: rtl/line_ctrl_pkg.sv
// rtl/line_ctrl_pkg.sv - shared constants and helpers for the line steering block
// Contents: FSM state encodings, stage-1 action codes, default PWM width,
// and a signed 32-bit saturate function.
package line_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int PWM_BITS_DEF = 10;

  // What stage 2 must do with the frame handed over by stage 1.
  localparam logic [1:0] ACT_NONE = 2'd0; // keep steer and pending duties
  localparam logic [1:0] ACT_PD   = 2'd1; // new steer from the PD products
  localparam logic [1:0] ACT_ZERO = 2'd2; // motors off, steer back to 0

  function automatic logic signed [31:0] sat_s32(input logic signed [31:0] v,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - two-channel PWM generator with period-boundary duty latch
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pend_left, pend_right    requested duties, taken only at counter wrap
//   duty_left, duty_right    duties currently applied
//   pwm_left, pwm_right      registered PWM outputs, high while cnt < duty
module pwm_gen
  import line_ctrl_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = 49
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pend_left,
  input  logic [PWM_BITS-1:0] pend_right,
  output logic [PWM_BITS-1:0] duty_left,
  output logic [PWM_BITS-1:0] duty_right,
  output logic                pwm_left,
  output logic                pwm_right
);

  localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic                pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic                tick, wrap;

  always_comb begin
    tick  = (pre_q == PRE_W'(PRESCALE));
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    // Duties change only as the counter rolls back to 0, so no period is cut short.
    wrap     = tick && (cnt_q == '1);
    duty_l_d = wrap ? pend_left  : duty_l_q;
    duty_r_d = wrap ? pend_right : duty_r_q;
    // Compare against next-cycle counter/duty so the output flop lines up with them.
    pwm_l_d  = (cnt_d < duty_l_d);
    pwm_r_d  = (cnt_d < duty_r_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      duty_l_q <= '0;
      duty_r_q <= '0;
      pwm_l_q  <= 1'b0;
      pwm_r_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      duty_l_q <= duty_l_d;
      duty_r_q <= duty_r_d;
      pwm_l_q  <= pwm_l_d;
      pwm_r_q  <= pwm_r_d;
    end
  end

  assign duty_left  = duty_l_q;
  assign duty_right = duty_r_q;
  assign pwm_left   = pwm_l_q;
  assign pwm_right  = pwm_r_q;

endmodule

// File: rtl/line_steer_pwm.sv
// rtl/line_steer_pwm.sv - PD line-follow steering with lost-line supervision and PWM
// Optional feature macro: STEER_SLEW_EN (limits per-frame steer change to SLEW_STEP).
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   enable                   0 forces IDLE and zero duties
//   err_valid                one-cycle strobe per frame
//   error, detected          signed centroid error and line-found flag
//   pwm_left, pwm_right      motor PWM outputs
//   duty_left, duty_right    duties currently applied to the PWM outputs
//   steer                    saturated steer of the last processed frame
//   state, lost              FSM state (0 IDLE,1 TRACK,2 HOLD,3 STOP), HOLD/STOP flag
module line_steer_pwm
  import line_ctrl_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int PRESCALE    = 49,
  parameter int KP          = 3,
  parameter int KD          = 2,
  parameter int GAIN_SHIFT  = 2,
  parameter int BASE_DUTY   = 512,
  parameter int STEER_MAX   = 400,
  parameter int LOST_FRAMES = 15,
  parameter int SLEW_STEP   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                err_valid,
  input  logic signed [15:0]  error,
  input  logic                detected,
  output logic                pwm_left,
  output logic                pwm_right,
  output logic [PWM_BITS-1:0] duty_left,
  output logic [PWM_BITS-1:0] duty_right,
  output logic signed [15:0]  steer,
  output logic [1:0]          state,
  output logic                lost
);

  localparam int         DUTY_MAX = (1 << PWM_BITS) - 1;
  localparam logic [7:0] LOST_LIM = 8'(LOST_FRAMES);

  // Stage 1: FSM decision, products, e_prev/lost_cnt bookkeeping.
  logic [1:0]         fsm_q, fsm_d;
  logic [7:0]         lost_cnt_q, lost_cnt_d;
  logic signed [15:0] e_prev_q, e_prev_d;
  logic [1:0]         act_q, act_d;
  logic signed [31:0] p_q, p_d, dd_q, dd_d;
  logic signed [31:0] err_ext, prev_ext;

  // Stage 2: sum/shift/saturate and duty mapping.
  logic [1:0]          state_q;
  logic signed [15:0]  steer_q, steer_d;
  logic [PWM_BITS-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic signed [31:0]  sum, shifted, sat, lim, left_v, right_v;

  always_comb begin
    err_ext    = {{16{error[15]}}, error};
    prev_ext   = {{16{e_prev_q[15]}}, e_prev_q};
    fsm_d      = fsm_q;
    lost_cnt_d = lost_cnt_q;
    e_prev_d   = e_prev_q;
    act_d      = ACT_NONE;
    p_d        = p_q;
    dd_d       = dd_q;
    if (!enable) begin
      fsm_d      = ST_IDLE;
      lost_cnt_d = 8'd0;
      act_d      = ACT_ZERO;
    end else if (err_valid) begin
      if (detected) begin
        fsm_d      = ST_TRACK;
        lost_cnt_d = 8'd0;
        e_prev_d   = error;
        act_d      = ACT_PD;
        p_d        = err_ext * KP;
        // e_prev is stale on (re)entry to TRACK, so the derivative is dropped.
        dd_d       = (fsm_q == ST_TRACK) ? (err_ext - prev_ext) * KD : 32'sd0;
      end else begin
        case (fsm_q)
          ST_TRACK, ST_HOLD: begin
            lost_cnt_d = (fsm_q == ST_TRACK) ? 8'd1 : lost_cnt_q + 8'd1;
            if (lost_cnt_d >= LOST_LIM) begin
              fsm_d = ST_STOP;
              act_d = ACT_ZERO;
            end else begin
              fsm_d = ST_HOLD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    steer_d  = steer_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    sum      = p_q + dd_q;
    shifted  = sum >>> GAIN_SHIFT;
    sat      = sat_s32(shifted, -STEER_MAX, STEER_MAX);
`ifdef STEER_SLEW_EN
    // steer_q is zeroed on IDLE/STOP entry, so slewing restarts from 0 there.
    lim      = sat_s32(sat, 32'(steer_q) - SLEW_STEP, 32'(steer_q) + SLEW_STEP);
`else
    lim      = sat;
`endif
    left_v   = sat_s32(BASE_DUTY + lim, 32'sd0, DUTY_MAX);
    right_v  = sat_s32(BASE_DUTY - lim, 32'sd0, DUTY_MAX);
    case (act_q)
      ACT_PD: begin
        steer_d  = lim[15:0];
        pend_l_d = left_v[PWM_BITS-1:0];
        pend_r_d = right_v[PWM_BITS-1:0];
      end
      ACT_ZERO: begin
        steer_d  = 16'sd0;
        pend_l_d = '0;
        pend_r_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q      <= ST_IDLE;
      lost_cnt_q <= 8'd0;
      e_prev_q   <= 16'sd0;
      act_q      <= ACT_NONE;
      p_q        <= 32'sd0;
      dd_q       <= 32'sd0;
      state_q    <= ST_IDLE;
      steer_q    <= 16'sd0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
    end else begin
      fsm_q      <= fsm_d;
      lost_cnt_q <= lost_cnt_d;
      e_prev_q   <= e_prev_d;
      act_q      <= act_d;
      p_q        <= p_d;
      dd_q       <= dd_d;
      // The visible state trails the stage-1 FSM by one cycle, in step with steer.
      state_q    <= fsm_q;
      steer_q    <= steer_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_pwm (
    .clk        (clk),
    .rst        (reset),
    .pend_left  (pend_l_q),
    .pend_right (pend_r_q),
    .duty_left  (duty_left),
    .duty_right (duty_right),
    .pwm_left   (pwm_left),
    .pwm_right  (pwm_right)
  );

  assign steer = steer_q;
  assign state = state_q;
  assign lost  = (state_q == ST_HOLD) || (state_q == ST_STOP);

endmodule

// File: tb/tb_line_steer_pwm.sv
// tb/tb_line_steer_pwm.sv - directed self-checking bench for line_steer_pwm
module tb_line_steer_pwm;

`ifdef STEER_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, enable, err_valid, detected;
  logic signed [15:0] error;
  logic              pwm_left, pwm_right, lost;
  logic [9:0]        duty_left, duty_right;
  logic signed [15:0] steer;
  logic [1:0]        state;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  line_steer_pwm #(.PRESCALE(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .err_valid  (err_valid),
    .error      (error),
    .detected   (detected),
    .pwm_left   (pwm_left),
    .pwm_right  (pwm_right),
    .duty_left  (duty_left),
    .duty_right (duty_right),
    .steer      (steer),
    .state      (state),
    .lost       (lost)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe one frame and return on the negedge where its stage-2 result is visible.
  task automatic frame(input int e, input logic det);
    @(negedge clk);
    err_valid = 1'b1;
    error     = 16'(e);
    detected  = det;
    @(negedge clk);
    err_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_duty(input string tag, input int exp_l, input int exp_r);
    int i;
    i = 0;
    while (int'(duty_left) != exp_l && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_duty_l"}, duty_left, exp_l);
    chk({tag, "_duty_r"}, duty_right, exp_r);
  endtask

  task automatic go_idle();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_s;
    reset = 1'b1; enable = 1'b0; err_valid = 1'b0; detected = 1'b0; error = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_steer", steer, 0);
    chk("rst_duty_l", duty_left, 0);
    chk("rst_pwm_l", pwm_left, 0);
    chk("rst_lost", lost, 0);
    reset = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);

    // 1: first frame from IDLE, D term dropped
    frame(40, 1'b1);
    chk("t1_state", state, 1);
    chk("t1_steer", steer, 30);
    chk("t1_duty_not_yet", duty_left, 0);
    wait_duty("t1", 542, 482);
    chk("t1_pwm_l", pwm_left, 1);
    chk("t1_pwm_r", pwm_right, 1);

    // 2: PD in TRACK, then negative error from IDLE, then floor of >>>
    frame(80, 1'b1);
    chk("t2_steer", steer, SLEW ? 62 : 80);
    wait_duty("t2", SLEW ? 574 : 592, SLEW ? 450 : 432);
    go_idle();
    chk("t2_idle_state", state, 0);
    frame(-40, 1'b1);
    chk("t2_neg_steer", steer, -30);
    wait_duty("t2_neg", 482, 542);
    frame(-41, 1'b1);
    chk("t2_floor_steer", steer, -32);

    // 3: saturation
    go_idle();
    frame(1000, 1'b1);
    chk("t3_sat1_steer", steer, SLEW ? 32 : 400);
    frame(2000, 1'b1);
    chk("t3_sat2_steer", steer, SLEW ? 64 : 400);
    for (int i = 3; i <= 14; i++) begin
      frame(2000, 1'b1);
      exp_s = (SLEW && 32 * i < 400) ? 32 * i : 400;
      chk($sformatf("t3_ramp%0d", i), steer, exp_s);
    end
    wait_duty("t3", 912, 112);

    // 4: lost line supervision
    frame(0, 1'b0);
    chk("t4_hold_state", state, 2);
    chk("t4_hold_lost", lost, 1);
    for (int k = 2; k <= 14; k++) frame(0, 1'b0);
    chk("t4_hold14_state", state, 2);
    chk("t4_hold14_steer", steer, 400);
    chk("t4_hold14_duty", duty_left, 912);
    frame(0, 1'b0);
    chk("t4_stop_state", state, 3);
    chk("t4_stop_lost", lost, 1);
    wait_duty("t4_stop", 0, 0);
    chk("t4_stop_pwm_l", pwm_left, 0);
    frame(40, 1'b1);
    chk("t4_resume_state", state, 1);
    chk("t4_resume_steer", steer, 30);
    chk("t4_resume_lost", lost, 0);

    // 5: enable drop wins over a strobe in the same cycle; async reset
    @(negedge clk);
    enable = 1'b0; err_valid = 1'b1; error = 16'sd80; detected = 1'b1;
    @(negedge clk);
    err_valid = 1'b0;
    @(negedge clk);
    chk("t5_idle_state", state, 0);
    wait_duty("t5_idle", 0, 0);
    enable = 1'b1;
    frame(40, 1'b1);
    chk("t5_track_steer", steer, 30);
    wait_duty("t5", 542, 482);
    chk("t5_pwm_high", pwm_left, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_pwm_l", pwm_left, 0);
    chk("t5_rst_pwm_r", pwm_right, 0);
    chk("t5_rst_state", state, 0);
    chk("t5_rst_duty", duty_left, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
